// File: rtl/axil_reg_pkg.sv
// Shared constants for the AXI4-Lite register slave: response codes,
// channel state encodings and the byte-to-word address shift.
package axil_reg_pkg;

  localparam int ADDR_LSB = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_reg_wstrb_merge.sv
// Byte-lane merge of a register's current value with incoming write data.
// Lanes whose strobe is set take WDATA, the rest keep the old value.
module axil_reg_wstrb_merge
  import axil_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_val,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   merged
);

  // Per-lane select between old and new byte
  always_comb begin
    merged = old_val;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Independent write (AW/W in any order, then B) and read (AR then R) engines.
// Build option: define AXIL_REG_SLVERR_EN to answer unmapped accesses with
// SLVERR; otherwise they answer OKAY. Unmapped writes are always dropped and
// unmapped reads always return zero.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

  wr_state_t wr_state, wr_state_nx;
  rd_state_t rd_state, rd_state_nx;
  logic      ready_en;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_p0;
  logic [DW-1:0]                 wdata_p0;
  logic [STRB_W-1:0]             wstrb_p0;

  logic                          aw_hs, w_hs, ar_hs, wr_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DW-1:0]                 wr_data_sel;
  logic [STRB_W-1:0]             wr_strb_sel;
  logic [IDX_W-1:0]              wr_idx, rd_idx;
  logic                          wr_mapped, rd_mapped;
  logic [DW-1:0]                 old_val, rd_val, merged;
  logic [DW-1:0]                 regs [NUM_REGS];
  logic                          unused_ok;

  // READY is held low until the first edge after reset release
  assign S_AXI_AWREADY = ready_en && (wr_state == W_IDLE || wr_state == W_HAVE_DATA);
  assign S_AXI_WREADY  = ready_en && (wr_state == W_IDLE || wr_state == W_HAVE_ADDR);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_ARREADY = ready_en && (rd_state == R_IDLE);
  assign S_AXI_RVALID  = (rd_state == R_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign wr_idx    = wr_addr_sel[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_mapped = {1'b0, wr_idx} < NUM_REGS_W;
  assign rd_mapped = {1'b0, rd_idx} < NUM_REGS_W;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       wr_addr_sel[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write FSM: commit as soon as both halves are in hand, from latch or bus
  always_comb begin
    wr_state_nx = wr_state;
    wr_commit   = 1'b0;
    wr_addr_sel = S_AXI_AWADDR;
    wr_data_sel = S_AXI_WDATA;
    wr_strb_sel = S_AXI_WSTRB;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit   = 1'b1;
          wr_state_nx = W_RESP;
        end else if (aw_hs) begin
          wr_state_nx = W_HAVE_ADDR;
        end else if (w_hs) begin
          wr_state_nx = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        wr_addr_sel = awaddr_p0;
        if (w_hs) begin
          wr_commit   = 1'b1;
          wr_state_nx = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        wr_data_sel = wdata_p0;
        wr_strb_sel = wstrb_p0;
        if (aw_hs) begin
          wr_commit   = 1'b1;
          wr_state_nx = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wr_state_nx = W_IDLE;
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  // Read FSM: one outstanding read, response held until RREADY
  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nx = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rd_state_nx = R_IDLE;
      default: rd_state_nx = R_IDLE;
    endcase
  end

  // Register-file lookups for the write merge and the read port
  always_comb begin
    old_val = '0;
    rd_val  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_idx == IDX_W'(k)) old_val = regs[k];
      if (rd_idx == IDX_W'(k)) rd_val  = regs[k];
    end
  end

  axil_reg_wstrb_merge #(.DATA_W(DW)) u_merge (
    .old_val (old_val),
    .wdata   (wr_data_sel),
    .wstrb   (wr_strb_sel),
    .merged  (merged)
  );

  // Channel state and READY enable
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      ready_en <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      rd_state <= rd_state_nx;
      ready_en <= 1'b1;
    end
  end

  // Hold an early AW or W until its partner arrives
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) awaddr_p0 <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_p0 <= S_AXI_WDATA;
      wstrb_p0 <= S_AXI_WSTRB;
    end
  end

  // Register update, write pulse and write response
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      reg_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_commit) begin
        S_AXI_BRESP <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_idx == IDX_W'(k)) begin
            regs[k]         <= merged;
            reg_wr_pulse[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Read data captured at AR acceptance (pre-write value on a same-cycle write)
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXI_RDATA <= rd_val;
      S_AXI_RRESP <= rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
    end
  end

  // Flatten the register file onto the user-logic bus
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) reg_out[DW*k +: DW] = regs[k];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized bench for axil_reg_slave with a word-array reference model.
// Honors AXIL_REG_SLVERR_EN for the expected unmapped response.
module tb_axil_reg_slave;

  localparam int AW   = 5;
  localparam int NREG = 4;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic tb_ACLK = 1'b0;
  logic aresetn = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic [AW-1:0]        awaddr = '0, araddr = '0;
  logic [2:0]           awprot = '0, arprot = '0;
  logic                 awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic                 awready, wready, bvalid, arready, rvalid;
  logic [31:0]          wdata = '0, rdata;
  logic [3:0]           wstrb = '0;
  logic [1:0]           bresp, rresp;
  logic [32*NREG-1:0]   reg_out;
  logic [NREG-1:0]      reg_wr_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [NREG];

  axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NREG)
  ) dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < NREG; k++)
      check($sformatf("%s_reg%0d", tag, k), reg_out[32*k +: 32], mdl[k]);
  endtask

  // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads W.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_wait);
    int aw_start, w_start, cyc, idx;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [NREG-1:0] exp_pulse;
    logic [1:0] exp_resp;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; aw_fire = 0; w_fire = 0; cyc = 0;
    while (cyc < 60) begin
      @(negedge tb_ACLK);
      if (aw_fire) begin awvalid = 0; aw_done = 1; aw_fire = 0; end
      if (w_fire)  begin wvalid  = 0; w_done  = 1; w_fire = 0; end
      if (aw_done && w_done) break;
      check("bvalid_early", bvalid, 1'b0);
      if (!aw_done && cyc == aw_start) begin awvalid = 1; awaddr = a; awprot = 3'($urandom); end
      if (!w_done && cyc == w_start)   begin wvalid = 1; wdata = d; wstrb = s; end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", aw_done && w_done, 1'b1);
      awvalid = 0; wvalid = 0;
      return;
    end
    idx = int'(a) / 4;
    exp_pulse = '0;
    exp_resp  = UNMAP_RESP;
    if (idx < NREG) begin
      mdl[idx] = model_merge(mdl[idx], d, s);
      exp_pulse[idx] = 1'b1;
      exp_resp = 2'b00;
    end
    check("bvalid", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check_regs("wr");
    for (int i = 0; i < b_wait; i++) begin
      @(negedge tb_ACLK);
      check("bvalid_hold", bvalid, 1'b1);
      check("bresp_hold", bresp, exp_resp);
      check("awready_in_resp", awready, 1'b0);
      check("wready_in_resp", wready, 1'b0);
    end
    bready = 1;
    @(negedge tb_ACLK);
    bready = 0;
    check("bvalid_done", bvalid, 1'b0);
    check("wr_pulse_clear", reg_wr_pulse, '0);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int r_wait);
    int idx, cyc;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    idx = int'(a) / 4;
    exp_data = (idx < NREG) ? mdl[idx] : 32'h0;
    exp_resp = (idx < NREG) ? 2'b00 : UNMAP_RESP;
    @(negedge tb_ACLK);
    arvalid = 1; araddr = a; arprot = 3'($urandom);
    cyc = 0;
    while (!arready && cyc < 20) begin @(negedge tb_ACLK); cyc++; end
    if (!arready) begin
      check("ar_timeout", arready, 1'b1);
      arvalid = 0;
      return;
    end
    @(negedge tb_ACLK);
    arvalid = 0;
    check("rvalid", rvalid, 1'b1);
    check($sformatf("rdata_0x%02h", a), rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int i = 0; i < r_wait; i++) begin
      @(negedge tb_ACLK);
      check("rdata_hold", rdata, exp_data);
      check("arready_in_resp", arready, 1'b0);
    end
    rready = 1;
    @(negedge tb_ACLK);
    rready = 0;
    check("rvalid_done", rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] wd [4];
    for (int k = 0; k < NREG; k++) mdl[k] = '0;

    // reset state
    #12;
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulse", reg_wr_pulse, '0);
    check_regs("rst");
    @(negedge tb_ACLK);
    aresetn = 1;
    #1 check("awready_before_edge", awready, 1'b0);
    @(posedge tb_ACLK);
    #1 check("awready_after_edge", awready, 1'b1);
    check("arready_after_edge", arready, 1'b1);

    // basic writes and readback
    wd[0] = 32'h0101FFFF; wd[1] = 32'hABCD0001; wd[2] = 32'hDEAD0011; wd[3] = 32'hBEEF0011;
    for (int k = 0; k < 4; k++) axi_write(AW'(4*k), wd[k], 4'hF, 0, 0);
    for (int k = 0; k < 4; k++) begin
      axi_read(AW'(4*k), 0);
      check($sformatf("basic_const%0d", k), reg_out[32*k +: 32], wd[k]);
    end

    // partial strobe
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(5'h00, 32'h12345678, 4'b0011, 0, 1);
    axi_read(5'h00, 0);
    check("partial_const", reg_out[31:0], 32'hFFFF5678);

    // empty strobe still completes
    axi_write(5'h08, 32'hCAFEBABE, 4'b0000, -2, 0);

    // W three cycles before AW, B held off five cycles
    axi_write(5'h08, 32'h0F0F0F0F, 4'hF, 3, 5);

    // unmapped access
    axi_write(5'h10, 32'h00000055, 4'hF, 0, 0);
    axi_read(5'h10, 1);
    check_regs("unmapped");

    // same-cycle read and write to 0x4
    @(negedge tb_ACLK);
    awvalid = 1; awaddr = 5'h04; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
    arvalid = 1; araddr = 5'h04;
    check("rw_awready", awready, 1'b1);
    check("rw_arready", arready, 1'b1);
    @(negedge tb_ACLK);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("rw_rdata_old", rdata, 32'hABCD0001);
    check("rw_bvalid", bvalid, 1'b1);
    mdl[1] = 32'h1;
    check_regs("rw");
    bready = 1; rready = 1;
    @(negedge tb_ACLK);
    bready = 0; rready = 0;
    axi_read(5'h04, 0);

    // randomized traffic, including unmapped and unaligned addresses
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(AW'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else
        axi_read(AW'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    // reset while both responses are pending
    @(negedge tb_ACLK);
    awvalid = 1; awaddr = 5'h0C; wvalid = 1; wdata = 32'h77777777; wstrb = 4'hF;
    arvalid = 1; araddr = 5'h00;
    @(negedge tb_ACLK);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("pre_rst_bvalid", bvalid, 1'b1);
    check("pre_rst_rvalid", rvalid, 1'b1);
    #2 aresetn = 0;
    #1;
    check("async_rst_bvalid", bvalid, 1'b0);
    check("async_rst_rvalid", rvalid, 1'b0);
    check("async_rst_awready", awready, 1'b0);
    for (int k = 0; k < NREG; k++) mdl[k] = '0;
    check_regs("async_rst");
    @(negedge tb_ACLK);
    aresetn = 1;
    @(posedge tb_ACLK);
    #1 check("post_rst_wready", wready, 1'b1);
    axi_write(5'h0C, 32'h13579BDF, 4'hF, 0, 2);
    axi_read(5'h0C, 2);
    axi_read(5'h04, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
